// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the proc instruction sequencer: opcode constants,
// FSM state encoding and a small opcode decode helper.
package proc_sequencer_pkg;

  localparam logic [2:0] MVI_OP  = 3'b001;
  localparam logic [2:0] HALT_OP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_IMM_F,
    S_IMM_L,
    S_ISSUE,
    S_EXEC
  } seq_state_e;

  function automatic logic [2:0] opcode(input logic [15:0] word);
    return word[15:13];
  endfunction

endpackage

// File: rtl/proc_sequencer_pc.sv
// Program counter for the sequencer: synchronous clear, increment, modulo-2**AW wrap.
module seq_pc #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr)      pc_d = '0;
    else if (inc) pc_d = pc_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/regn.sv
// Generic n-bit load-enable register used for the instruction and immediate latches.
module regn #(
  parameter int n = 16
) (
  input  logic [n-1:0] R,
  input  logic         Rin,
  input  logic         Clock,
  input  logic         Resetn,
  output logic [n-1:0] Q
);

  logic [n-1:0] q_q;
  logic [n-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (Rin) q_d = R;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) q_q <= '0;
    else         q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/proc_sequencer.sv
// Autonomous instruction sequencer: fetches words from a 1-cycle-latency ROM,
// issues them to proc with a Run pulse, waits for Done and stops on HALT/Stop/timeout.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 7
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Stop,
  output logic [AW-1:0] MemAddr,
  input  logic [15:0]   MemData,
  output logic [15:0]   ProcDIN,
  output logic          ProcRun,
  input  logic          ProcDone,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [15:0]   InstrCount
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  seq_state_e     state_q, state_d;
  logic           stop_q, stop_d;
  logic           halted_q, halted_d;
  logic           error_q, error_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic           pc_clr, pc_inc;
  logic           instr_en, imm_en;
  logic [15:0]    instr_q, imm_q;
  logic [AW-1:0]  pc;
  logic           is_mvi;

  seq_pc #(.AW(AW)) u_pc (
    .clk   (Clock),
    .rst_n (Resetn),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .pc    (pc)
  );

  regn #(.n(16)) u_instr (
    .R      (MemData),
    .Rin    (instr_en),
    .Clock  (Clock),
    .Resetn (Resetn),
    .Q      (instr_q)
  );

  regn #(.n(16)) u_imm (
    .R      (MemData),
    .Rin    (imm_en),
    .Clock  (Clock),
    .Resetn (Resetn),
    .Q      (imm_q)
  );

  assign is_mvi = (opcode(instr_q) == MVI_OP);

  always_comb begin
    state_d  = state_q;
    stop_d   = stop_q;
    halted_d = halted_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;
    instr_en = 1'b0;
    imm_en   = 1'b0;

    if (state_q != S_IDLE && Stop) stop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          pc_clr   = 1'b1;
          halted_d = 1'b0;
          error_d  = 1'b0;
          cnt_d    = '0;
          stop_d   = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        instr_en = 1'b1;
        pc_inc   = 1'b1;
        if (opcode(MemData) == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else if (opcode(MemData) == MVI_OP) begin
          state_d = S_IMM_F;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_IMM_F: state_d = S_IMM_L;
      S_IMM_L: begin
        imm_en  = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Timeout fires at the end of the TIMEOUT-th EXEC cycle, hence the compare on the next value.
        wdog_d = wdog_q + WDW'(1);
        if (ProcDone) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = (stop_q || Stop) ? S_IDLE : S_FETCH;
        end else if (wdog_d == WDW'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      stop_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      stop_q   <= stop_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
    end
  end

  // DIN is zero through FETCH/LATCH/IMM_*, which always follow IDLE or EXEC->FETCH.
  always_comb begin
    ProcDIN = '0;
    if (state_q == S_ISSUE)     ProcDIN = instr_q;
    else if (state_q == S_EXEC) ProcDIN = is_mvi ? imm_q : instr_q;
  end

  assign ProcRun    = (state_q == S_ISSUE);
  assign Busy       = (state_q != S_IDLE);
  assign MemAddr    = pc;
  assign Halted     = halted_q;
  assign Error      = error_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: 256x16 ROM with 1-cycle latency, a small proc model,
// and a scoreboard of expected issued / executing DIN words.
module tb_proc_sequencer;

  localparam int AW = 8;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] exec_din;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, force_nodone;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data, proc_din, instr_count;
  logic          proc_run, proc_done, model_done, busy, halted, error;

  logic [15:0] rom [256];
  logic [15:0] R [8];

  int   total = 0, bad = 0, runs = 0;
  exp_t exp_q[$];
  int   exec_lens[$];

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  // proc model: instruction word fields op=[15:13], rx=[9:7], ry=[6:4].
  // Done is high while idle; mv/mvi finish in the 1st EXEC cycle, add/sub in the 3rd.
  logic       m_busy;
  logic [1:0] m_step, m_need;
  logic [2:0] m_op, m_rx, m_ry;

  assign model_done = !m_busy || (m_step == m_need);
  assign proc_done  = model_done && !force_nodone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_step <= 2'd0; m_need <= 2'd1;
      m_op <= 3'd0; m_rx <= 3'd0; m_ry <= 3'd0;
      for (int i = 0; i < 8; i++) R[i] <= 16'h0;
    end else if (!m_busy) begin
      if (proc_run) begin
        m_busy <= 1'b1;
        m_step <= 2'd1;
        m_op   <= proc_din[15:13];
        m_rx   <= proc_din[9:7];
        m_ry   <= proc_din[6:4];
        m_need <= (proc_din[15:13] == 3'b010 || proc_din[15:13] == 3'b011) ? 2'd3 : 2'd1;
      end
    end else if (m_step == m_need) begin
      m_busy <= 1'b0;
      case (m_op)
        3'b000: R[m_rx] <= R[m_ry];
        3'b001: R[m_rx] <= proc_din;
        3'b010: R[m_rx] <= R[m_rx] + R[m_ry];
        3'b011: R[m_rx] <= R[m_rx] - R[m_ry];
        default: ;
      endcase
    end else begin
      m_step <= m_step + 2'd1;
    end
  end

  proc_sequencer #(.AW(AW), .TIMEOUT(7)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .Start      (start),
    .Stop       (stop),
    .MemAddr    (mem_addr),
    .MemData    (mem_data),
    .ProcDIN    (proc_din),
    .ProcRun    (proc_run),
    .ProcDone   (proc_done),
    .Busy       (busy),
    .Halted     (halted),
    .Error      (error),
    .InstrCount (instr_count)
  );

  // Pops one expectation per Run pulse; checks the issued word and the first EXEC word.
  task automatic monitor();
    bit          chk = 0, in_flight = 0;
    logic [15:0] want_exec = '0;
    int          len = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk = 0; in_flight = 0;
      end else begin
        if (chk) begin
          chk = 0; total++;
          if (proc_din !== want_exec) begin bad++; $display("FAIL exec_din: got %h want %h", proc_din, want_exec); end
        end
        if (proc_run) begin
          runs++; total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL issue_unexpected: got %h want none", proc_din);
          end else begin
            e = exp_q.pop_front();
            if (proc_din !== e.instr) begin bad++; $display("FAIL issue_din: got %h want %h", proc_din, e.instr); end
            chk = 1; want_exec = e.exec_din;
          end
          in_flight = 1; len = 0;
        end else if (in_flight) begin
          len++;
          if (proc_done) begin exec_lens.push_back(len); in_flight = 0; end
        end
        if (!busy) in_flight = 0;
      end
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_and_measure(output int lat);
    start = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (proc_run) break;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    total++;
    if (busy) begin bad++; $display("FAIL %s_idle_timeout: got busy=%b want 0", name, busy); end
  endtask

  task automatic wait_runs(input int n, input string name);
    int seen = 0, cyc = 0;
    while (seen < n && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (proc_run) seen++;
    end
    total++;
    if (seen != n) begin bad++; $display("FAIL %s_runs_timeout: got %0d want %0d", name, seen, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; force_nodone = 1'b0;
    rom_clear();
    repeat (2) @(negedge clk);
    total++;
    if ({mem_addr, proc_din, proc_run, busy, halted, error, instr_count} !== '0) begin
      bad++; $display("FAIL reset_outputs: got addr=%h din=%h run=%b busy=%b halt=%b err=%b cnt=%h want all 0",
                      mem_addr, proc_din, proc_run, busy, halted, error, instr_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_mvi_halt();
    int lat, base;
    rom_clear();
    rom[0] = 16'h2000; rom[1] = 16'h0005; rom[2] = 16'hE000;
    exp_q.push_back({16'h2000, 16'h0005});
    exec_lens.delete(); base = runs;
    start_and_measure(lat);
    total++; if (lat != 5) begin bad++; $display("FAIL t1_latency: got %0d want 5", lat); end
    wait_idle("t1");
    total++; if (runs - base != 1) begin bad++; $display("FAIL t1_runs: got %0d want 1", runs - base); end
    total++; if (exec_lens.size() != 1 || exec_lens[0] != 1) begin bad++; $display("FAIL t1_exec_len: got n=%0d len=%0d want n=1 len=1", exec_lens.size(), exec_lens[0]); end
    total++; if (R[0] !== 16'h0005) begin bad++; $display("FAIL t1_r0: got %h want 0005", R[0]); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL t1_halted: got %b want 1", halted); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL t1_count: got %0d want 1", instr_count); end
    total++; if (mem_addr !== 8'd3) begin bad++; $display("FAIL t1_pc: got %0d want 3", mem_addr); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL t1_error: got %b want 0", error); end
  endtask

  task automatic test_add_exec();
    int lat, base;
    rom_clear();
    // 16'h4090 is add R1,R1 in the model's field layout.
    rom[0] = 16'h2080; rom[1] = 16'h0003; rom[2] = 16'h4090; rom[3] = 16'hE000;
    exp_q.push_back({16'h2080, 16'h0003});
    exp_q.push_back({16'h4090, 16'h4090});
    exec_lens.delete(); base = runs;
    start_and_measure(lat);
    total++; if (lat != 5) begin bad++; $display("FAIL t2_latency: got %0d want 5", lat); end
    wait_runs(1, "t2");
    start_pulse();
    wait_idle("t2");
    total++; if (runs - base != 2) begin bad++; $display("FAIL t2_runs: got %0d want 2", runs - base); end
    total++; if (exec_lens.size() != 2 || exec_lens[1] != 3) begin bad++; $display("FAIL t2_add_len: got n=%0d len=%0d want n=2 len=3", exec_lens.size(), exec_lens[1]); end
    total++; if (R[1] !== 16'd6) begin bad++; $display("FAIL t2_r1: got %0d want 6", R[1]); end
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL t2_count: got %0d want 2", instr_count); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL t2_halted: got %b want 1", halted); end
  endtask

  task automatic test_stop();
    int lat, base;
    rom_clear();
    for (int i = 0; i < 8; i++) rom[i] = 16'h4090;
    exp_q.push_back({16'h4090, 16'h4090});
    exp_q.push_back({16'h4090, 16'h4090});
    base = runs;
    start_and_measure(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL t3_latency: got %0d want 3", lat); end
    wait_runs(1, "t3");
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle("t3");
    total++; if (runs - base != 2) begin bad++; $display("FAIL t3_runs: got %0d want 2", runs - base); end
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL t3_count: got %0d want 2", instr_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL t3_halted: got %b want 0", halted); end
    total++; if (mem_addr !== 8'd2) begin bad++; $display("FAIL t3_pc: got %0d want 2", mem_addr); end
  endtask

  task automatic test_timeout();
    int lat, n;
    rom_clear();
    rom[0] = 16'h0000; rom[1] = 16'h4090;
    exp_q.push_back({16'h0000, 16'h0000});
    exp_q.push_back({16'h4090, 16'h4090});
    start_and_measure(lat);
    wait_runs(1, "t4");
    force_nodone = 1'b1;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    force_nodone = 1'b0;
    total++; if (n != 8) begin bad++; $display("FAIL t4_exec_cycles: got %0d want 8", n); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL t4_error: got %b want 1", error); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL t4_count: got %0d want 1", instr_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL t4_halted: got %b want 0", halted); end
    rom_clear();
    rom[0] = 16'hE000;
    start_pulse();
    wait_idle("t4b");
    total++; if (error !== 1'b0) begin bad++; $display("FAIL t4_error_clear: got %b want 0", error); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL t4_halted_b: got %b want 1", halted); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL t4_count_b: got %0d want 0", instr_count); end
  endtask

  task automatic test_pc_wrap();
    int lat;
    rom_clear();
    rom[255] = 16'h2000;
    for (int i = 0; i < 255; i++) exp_q.push_back({16'h0000, 16'h0000});
    exp_q.push_back({16'h2000, 16'h0000});
    start_and_measure(lat);
    wait_runs(255, "t5");
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle("t5");
    total++; if (mem_addr !== 8'd1) begin bad++; $display("FAIL t5_pc: got %0d want 1", mem_addr); end
    total++; if (instr_count !== 16'd256) begin bad++; $display("FAIL t5_count: got %0d want 256", instr_count); end
    total++; if (R[0] !== 16'h0000) begin bad++; $display("FAIL t5_r0: got %h want 0000", R[0]); end
  endtask

  task automatic test_reset_mid();
    int lat;
    rom_clear();
    rom[0] = 16'h4090; rom[1] = 16'hE000;
    exp_q.push_back({16'h4090, 16'h4090});
    start_and_measure(lat);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_addr, proc_din, proc_run, busy, halted, error, instr_count} !== '0) begin
      bad++; $display("FAIL t6_async_reset: got addr=%h din=%h run=%b busy=%b cnt=%h want all 0",
                      mem_addr, proc_din, proc_run, busy, instr_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({16'h4090, 16'h4090});
    start_and_measure(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL t6_latency: got %0d want 3", lat); end
    wait_idle("t6");
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL t6_halted: got %b want 1", halted); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL t6_count: got %0d want 1", instr_count); end
    total++; if (mem_addr !== 8'd2) begin bad++; $display("FAIL t6_pc: got %0d want 2", mem_addr); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_mvi_halt();
    test_add_exec();
    test_stop();
    test_timeout();
    test_pc_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
